// File: rtl/riscv_pkg.sv
// Shared definitions for the core front end.
//   XLEN          : default datapath/address width
//   NOP_INSTR     : canonical NOP (addi x0,x0,0), the slot's reset contents
//   fetch_state_e : fetch FSM encoding (BOOT, REQ, WAIT, HOLD, TRAP)
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fixed encodings so older tooling that compares raw state bits keeps working.
    localparam logic [2:0] ST_BOOT = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_TRAP = 3'd4;

    typedef enum logic [2:0] {
        FS_BOOT = ST_BOOT,
        FS_REQ  = ST_REQ,
        FS_WAIT = ST_WAIT,
        FS_HOLD = ST_HOLD,
        FS_TRAP = ST_TRAP
    } fetch_state_e;

endpackage

// File: rtl/fetch_slot.sv
// One-entry output slot feeding the IF/ID registers.
//   clk, rst_n      : clock, async active-low reset
//   load_i          : capture load_pc_i/load_instr_i and mark valid
//   load_pc_i       : PC of the word being loaded
//   load_instr_i    : instruction word being loaded
//   consume_i       : downstream took the entry this cycle
//   clear_i         : drop the entry (flush/redirect); beats load and consume
//   valid_o/pc_o/instr_o : registered slot contents
module fetch_slot #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic [31:0]     load_instr_i,
    input  logic            consume_i,
    input  logic            clear_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o
);
    import riscv_pkg::*;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            if (clear_i)        valid_q <= 1'b0;
            else if (load_i)    valid_q <= 1'b1;
            else if (consume_i) valid_q <= 1'b0;
            // pc/instr keep their last value after clear so the bus stays quiet
            if (load_i && !clear_i) begin
                pc_q    <= load_pc_i;
                instr_q <= load_instr_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem request
// (req/gnt/rvalid), one-entry output slot, redirect/flush handling.
//   clk, rst_n                        : clock, async active-low reset
//   stall_i / flush_i                 : IF/ID enable (inverted) / clear
//   redirect_valid_i, redirect_pc_i   : PC load from execute (wins over stall/flush)
//   imem_req_o, imem_addr_o           : registered fetch request
//   imem_gnt_i, imem_rvalid_i, imem_rdata_i : memory handshake
//   if_valid_o, if_pc_o, if_instr_o   : slot contents
//   misalign_o                        : sticky misaligned-redirect flag
// Build option: FETCH_MISALIGN_TRAP_EN -- misaligned redirects park the FSM in
// TRAP and raise misalign_o; without it the low PC bits are forced to zero.
module fetch_unit #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    output logic            misalign_o
);
    import riscv_pkg::*;

    fetch_state_e    state_q, state_d, drop_to;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic            misalign_q, misalign_d;
    logic            req_q;
    logic [XLEN-1:0] addr_q;

    logic [XLEN-1:0] redir_pc;
    logic            redir_go, redir_bad;
    logic            slot_load, slot_clear, slot_consume;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_pc  = redirect_pc_i;
    assign redir_bad = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
    logic unused_redir_lo;
    assign unused_redir_lo = ^redirect_pc_i[1:0];
    assign redir_pc  = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign redir_bad = 1'b0;
`endif
    assign redir_go     = redirect_valid_i && !redir_bad;
    assign slot_consume = if_valid_o && !stall_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        misalign_d = misalign_q;
        slot_load  = 1'b0;
        slot_clear = redirect_valid_i || flush_i;

        if (redir_go) begin
            pc_d       = redir_pc;
            misalign_d = 1'b0;
        end else if (redir_bad) begin
            misalign_d = 1'b1;
        end

        // Where the FSM goes once nothing is in flight: a pending misaligned
        // redirect parks it, otherwise it fetches pc_d.
        drop_to = misalign_d ? FS_TRAP : FS_REQ;

        case (state_q)
            FS_BOOT: state_d = drop_to;
            FS_REQ: begin
                if (imem_gnt_i) begin
                    state_d = FS_WAIT;
                    // request for the old PC already accepted; kill its response
                    if (redirect_valid_i) discard_d = 1'b1;
                end else if (redir_bad) begin
                    state_d = FS_TRAP;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid_i) begin
                    if (discard_q || redirect_valid_i || flush_i) begin
                        // pc_q was never advanced for this word, so REQ refetches
                        // the right address (or the redirect target)
                        discard_d = 1'b0;
                        state_d   = drop_to;
                    end else begin
                        slot_load = 1'b1;
                        pc_d      = pc_q + XLEN'(PC_STEP);
                        state_d   = FS_HOLD;
                    end
                end else if (redirect_valid_i || flush_i) begin
                    discard_d = 1'b1;
                end
            end
            FS_HOLD: begin
                if (redirect_valid_i)             state_d = drop_to;
                else if (flush_i || slot_consume) state_d = FS_REQ;
            end
            FS_TRAP: if (redir_go) state_d = FS_REQ;
            default: state_d = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_BOOT;
            pc_q       <= RESET_PC[XLEN-1:0];
            discard_q  <= 1'b0;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC[XLEN-1:0];
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            misalign_q <= misalign_d;
            // request lines registered off next state so REQ always sees req=1, addr=pc_q
            req_q      <= (state_d == FS_REQ);
            addr_q     <= pc_d;
        end
    end

    fetch_slot #(.XLEN(XLEN)) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (slot_load),
        .load_pc_i    (pc_q),
        .load_instr_i (imem_rdata_i),
        .consume_i    (slot_consume),
        .clear_i      (slot_clear),
        .valid_o      (if_valid_o),
        .pc_o         (if_pc_o),
        .instr_o      (if_instr_o)
    );

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] B6 = 32'h0000_0200;
`else
    localparam logic [31:0] B6 = 32'h0000_0100;
`endif
    localparam logic [31:0] TOP = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0, redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o, if_instr_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_instr_o       (if_instr_o),
        .misalign_o       (misalign_o)
    );

    typedef struct {
        logic stall, flush, rv;
        logic [31:0] rpc;
        logic gnt, rvalid;
        logic [31:0] rdata;
    } in_t;

    typedef struct {
        logic req;
        logic [31:0] addr;
        logic valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic mis;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    // memory contents: tag the address so each word is recognisable
    function automatic logic [31:0] D(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    function automatic in_t I(input bit s, input bit f, input bit rv, input logic [31:0] rpc,
                              input bit g, input bit r, input logic [31:0] rd);
        in_t t;
        t.stall = s; t.flush = f; t.rv = rv; t.rpc = rpc;
        t.gnt = g; t.rvalid = r; t.rdata = rd;
        return t;
    endfunction

    function automatic out_t O(input bit req, input logic [31:0] addr, input bit v,
                               input logic [31:0] pc, input logic [31:0] instr, input bit mis);
        out_t t;
        t.req = req; t.addr = addr; t.valid = v; t.pc = pc; t.instr = instr; t.mis = mis;
        return t;
    endfunction

    function automatic in_t IDLE();  return I(0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic in_t GNT();   return I(0, 0, 0, 0, 1, 0, 0); endfunction
    function automatic in_t RV(input logic [31:0] d); return I(0, 0, 0, 0, 0, 1, d); endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i; v.o = o;
        vq.push_back(v);
    endtask

    task automatic drive(input in_t i);
        stall_i = i.stall; flush_i = i.flush; redirect_valid_i = i.rv; redirect_pc_i = i.rpc;
        imem_gnt_i = i.gnt; imem_rvalid_i = i.rvalid; imem_rdata_i = i.rdata;
    endtask

    task automatic check(input string name, input out_t e);
        checks++;
        if ({imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, misalign_o} !==
            {e.req, e.addr, e.valid, e.pc, e.instr, e.mis}) begin
            errors++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h mis=%0b ; want req=%0b addr=%h valid=%0b pc=%h instr=%h mis=%0b",
                     name, imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, misalign_o,
                     e.req, e.addr, e.valid, e.pc, e.instr, e.mis);
        end
    endtask

    task automatic step(input string name, input in_t i, input out_t e);
        @(negedge clk);
        drive(i);
        @(posedge clk);
        #1;
        check(name, e);
    endtask

    initial begin
        // sequential zero-wait fetch 0x0, 0x4, 0x8
        add(IDLE(),      O(1, 32'h0, 0, 32'h0, NOP,     0));
        add(GNT(),       O(0, 32'h0, 0, 32'h0, NOP,     0));
        add(RV(D(32'h0)), O(0, 32'h4, 1, 32'h0, D(32'h0), 0));
        add(IDLE(),      O(1, 32'h4, 0, 32'h0, D(32'h0), 0));
        add(GNT(),       O(0, 32'h4, 0, 32'h0, D(32'h0), 0));
        add(RV(D(32'h4)), O(0, 32'h8, 1, 32'h4, D(32'h4), 0));
        add(IDLE(),      O(1, 32'h8, 0, 32'h4, D(32'h4), 0));
        add(GNT(),       O(0, 32'h8, 0, 32'h4, D(32'h4), 0));
        add(RV(D(32'h8)), O(0, 32'hC, 1, 32'h8, D(32'h8), 0));
        // stall 5 cycles with slot full, then release
        for (int k = 0; k < 5; k++)
            add(I(1, 0, 0, 0, 0, 0, 0), O(0, 32'hC, 1, 32'h8, D(32'h8), 0));
        add(IDLE(),      O(1, 32'hC, 0, 32'h8, D(32'h8), 0));
        add(GNT(),       O(0, 32'hC, 0, 32'h8, D(32'h8), 0));
        // redirect during WAIT: stale word for 0xC dropped
        add(I(0, 0, 1, 32'h100, 0, 0, 0), O(0, 32'h100, 0, 32'h8, D(32'h8), 0));
        add(RV(D(32'hC)),  O(1, 32'h100, 0, 32'h8,   D(32'h8),   0));
        add(GNT(),         O(0, 32'h100, 0, 32'h8,   D(32'h8),   0));
        add(RV(D(32'h100)), O(0, 32'h104, 1, 32'h100, D(32'h100), 0));
        add(IDLE(),        O(1, 32'h104, 0, 32'h100, D(32'h100), 0));
        // redirect together with gnt in REQ
        add(I(0, 0, 1, 32'h100, 1, 0, 0), O(0, 32'h100, 0, 32'h100, D(32'h100), 0));
        add(RV(D(32'h104)), O(1, 32'h100, 0, 32'h100, D(32'h100), 0));
        add(GNT(),          O(0, 32'h100, 0, 32'h100, D(32'h100), 0));
        add(RV(D(32'h100)), O(0, 32'h104, 1, 32'h100, D(32'h100), 0));
        // flush + stall with slot full: flush wins, fetch continues at pc+4
        add(I(1, 1, 0, 0, 0, 0, 0), O(1, 32'h104, 0, 32'h100, D(32'h100), 0));
        add(GNT(),          O(0, 32'h104, 0, 32'h100, D(32'h100), 0));
        add(RV(D(32'h104)), O(0, 32'h108, 1, 32'h104, D(32'h104), 0));
        // redirect beats stall in HOLD; PC wraps past 0xFFFFFFFC
        add(I(1, 0, 1, TOP, 0, 0, 0), O(1, TOP, 0, 32'h104, D(32'h104), 0));
        add(GNT(),          O(0, TOP,   0, 32'h104, D(32'h104), 0));
        add(RV(D(TOP)),     O(0, 32'h0, 1, TOP,     D(TOP),     0));
        add(IDLE(),         O(1, 32'h0, 0, TOP,     D(TOP),     0));
        // misaligned redirect to 0x102
`ifdef FETCH_MISALIGN_TRAP_EN
        add(I(0, 0, 1, 32'h102, 0, 0, 0), O(0, 32'h0, 0, TOP, D(TOP), 1));
        add(IDLE(),         O(0, 32'h0,   0, TOP,     D(TOP),     1));
        add(I(0, 0, 1, 32'h200, 0, 0, 0), O(1, 32'h200, 0, TOP, D(TOP), 0));
        add(GNT(),          O(0, 32'h200, 0, TOP,     D(TOP),     0));
        add(RV(D(32'h200)), O(0, 32'h204, 1, 32'h200, D(32'h200), 0));
`else
        add(I(0, 0, 1, 32'h102, 0, 0, 0), O(1, 32'h100, 0, TOP, D(TOP), 0));
        add(GNT(),          O(0, 32'h100, 0, TOP,     D(TOP),     0));
        add(RV(D(32'h100)), O(0, 32'h104, 1, 32'h100, D(32'h100), 0));
`endif

        // reset state
        drive(IDLE());
        repeat (2) @(posedge clk);
        #1;
        check("reset", O(0, 32'h0, 0, 32'h0, NOP, 0));
        rst_n = 1'b1;

        for (int k = 0; k < vq.size(); k++)
            step($sformatf("vec%0d", k), vq[k].i, vq[k].o);

        // reset asserted while a request is in flight
        step("pre_rst_req",  IDLE(), O(1, B6 + 32'h4, 0, B6, D(B6), 0));
        step("pre_rst_wait", GNT(),  O(0, B6 + 32'h4, 0, B6, D(B6), 0));
        @(negedge clk);
        drive(IDLE());
        rst_n = 1'b0;
        #1;
        check("async_reset", O(0, 32'h0, 0, 32'h0, NOP, 0));
        repeat (2) @(posedge clk);
        #1;
        // late response for the killed request arrives as reset releases
        drive(RV(D(B6 + 32'h4)));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("boot_late_rvalid", O(1, 32'h0, 0, 32'h0, NOP, 0));
        step("req_late_rvalid", RV(D(B6 + 32'h4)), O(1, 32'h0, 0, 32'h0, NOP, 0));
        step("post_rst_gnt",    GNT(),             O(0, 32'h0, 0, 32'h0, NOP, 0));
        // flush in WAIT: response dropped, same address refetched
        step("wait_flush",      I(0, 1, 0, 0, 0, 0, 0), O(0, 32'h0, 0, 32'h0, NOP, 0));
        step("wait_flush_drop", RV(D(32'h0)),      O(1, 32'h0, 0, 32'h0, NOP, 0));
        step("refetch_gnt",     GNT(),             O(0, 32'h0, 0, 32'h0, NOP, 0));
        step("refetch_data",    RV(D(32'h0)),      O(0, 32'h4, 1, 32'h0, D(32'h0), 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
